// File: rtl/config_frame_loader.sv
// config_frame_loader
//   Turns a 32-bit header/data word stream into frame writes on one tile
//   column's configuration latches. A header selects the frame. NumRows
//   data words then fill FrameData one row slice at a time. FrameStrobe
//   then pulses one-hot, with one setup cycle before the pulse and one hold
//   cycle after it. FrameData stays frozen during the setup, pulse and hold
//   cycles.
//
// Ports
//   CLK          system clock, rising edge
//   reset        synchronous active-high reset
//   in_data      stream word (header or frame data)
//   in_valid     in_data valid
//   in_ready     loader can take a word (registered, state-derived only)
//   clear_err    clears the sticky error flag
//   FrameData    frame data to the latches, NumRows slices of 32 bits
//   FrameStrobe  one-hot frame write strobe
//   busy         high whenever the sequencer is not idle
//   err          sticky protocol error (bad sync or out-of-range index)
//   frame_count  frames written, wraps at 16 bits
module config_frame_loader #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 1,
    parameter int StrobeCycles    = 2
) (
    input  logic                                 CLK,
    input  logic                                 reset,
    input  logic [31:0]                          in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 clear_err,
    output logic [FrameBitsPerRow*NumRows-1:0]   FrameData,
    output logic [MaxFramesPerCol-1:0]           FrameStrobe,
    output logic                                 busy,
    output logic                                 err,
    output logic [15:0]                          frame_count
);

    localparam int         RW   = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int         SW   = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam logic [7:0] SYNC = 8'hFA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DISCARD,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t                                  r_state;
    state_t                                  w_next;
    logic [RW-1:0]                           r_row;
    logic [SW-1:0]                           r_scnt;
    logic [7:0]                              r_idx;
    logic [NumRows-1:0][FrameBitsPerRow-1:0] r_data;
    logic [MaxFramesPerCol-1:0]              r_strobe;
    logic                                    r_ready;
    logic                                    r_busy;
    logic                                    r_err;
    logic [15:0]                             r_frame_cnt;

    logic                                    w_xfer;
    logic                                    w_sync_ok;
    logic                                    w_idx_ok;
    logic                                    w_last_row;
    logic                                    w_last_strobe;
    logic                                    w_err_set;
    logic [MaxFramesPerCol-1:0]              w_strobe_vec;
    logic                                    w_unused_hdr;

    assign w_xfer        = in_valid && in_ready;
    assign w_sync_ok     = (in_data[31:24] == SYNC);
    assign w_idx_ok      = (32'(in_data[7:0]) < MaxFramesPerCol);
    assign w_last_row    = (r_row == RW'(NumRows - 1));
    assign w_last_strobe = (r_scnt == SW'(StrobeCycles - 1));
    assign w_strobe_vec  = {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << r_idx;
    // Header bits [23:8] carry nothing for this block.
    assign w_unused_hdr  = ^in_data[23:8];

    // Next-state logic and error-set detection.
    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (!w_sync_ok) begin
                        w_err_set = 1'b1;
                    end else if (w_idx_ok) begin
                        w_next = S_LOAD;
                    end else begin
                        w_err_set = 1'b1;
                        w_next    = S_DISCARD;
                    end
                end
            end
            S_LOAD:    if (w_xfer && w_last_row) w_next = S_SETUP;
            S_DISCARD: if (w_xfer && w_last_row) w_next = S_IDLE;
            S_SETUP:   w_next = S_STROBE;
            S_STROBE:  if (w_last_strobe) w_next = S_HOLD;
            S_HOLD:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Registered outputs are computed from the next state so they line up
    // with the state they describe, without any path from in_valid.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_row       <= '0;
            r_scnt      <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_strobe    <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_ready  <= (w_next == S_IDLE) || (w_next == S_LOAD) || (w_next == S_DISCARD);
            r_busy   <= (w_next != S_IDLE);
            r_strobe <= (w_next == S_STROBE) ? w_strobe_vec : '0;

            if (r_state == S_IDLE && w_xfer) begin
                r_idx <= in_data[7:0];
                r_row <= '0;
            end else if ((r_state == S_LOAD || r_state == S_DISCARD) && w_xfer) begin
                r_row <= r_row + RW'(1);
            end

            if (r_state == S_LOAD && w_xfer)
                r_data[r_row] <= in_data;

            if (r_state == S_STROBE) r_scnt <= r_scnt + SW'(1);
            else                     r_scnt <= '0;

            if (r_state == S_HOLD)
                r_frame_cnt <= r_frame_cnt + 16'd1;

            // A new error in the same cycle as clear_err keeps err set.
            if (w_err_set)      r_err <= 1'b1;
            else if (clear_err) r_err <= 1'b0;
        end
    end

    assign in_ready    = r_ready;
    assign busy        = r_busy;
    assign err         = r_err;
    assign FrameData   = r_data;
    assign FrameStrobe = r_strobe;
    assign frame_count = r_frame_cnt;

endmodule

// File: tb/tb_config_frame_loader.sv
module tb_config_frame_loader;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        clear_err = 1'b0;
    logic        in_ready;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        busy, err;
    logic [15:0] frame_count;

    logic [31:0] in_data3 = '0;
    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [95:0] FrameData3;
    logic [19:0] FrameStrobe3;
    logic        busy3, err3;
    logic [15:0] frame_count3;

    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] exp_data = '0;
    logic [15:0] exp_cnt = '0;

    always #5 CLK = ~CLK;

    config_frame_loader u_dut (
        .CLK(CLK), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .clear_err(clear_err), .FrameData(FrameData),
        .FrameStrobe(FrameStrobe), .busy(busy), .err(err), .frame_count(frame_count)
    );

    config_frame_loader #(.NumRows(3)) u_dut3 (
        .CLK(CLK), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .clear_err(1'b0), .FrameData(FrameData3),
        .FrameStrobe(FrameStrobe3), .busy(busy3), .err(err3), .frame_count(frame_count3)
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Strobe one-hot-or-zero and FrameData stability around every strobe.
    logic [19:0] m_prev_strobe;
    logic [31:0] m_prev_data;
    logic        m_rst_edge;
    always @(posedge CLK) m_rst_edge <= reset;
    always @(negedge CLK) begin
        if (m_rst_edge === 1'b0) begin
            n_checks++;
            if (!$onehot0(FrameStrobe)) begin
                n_err++;
                $display("FAIL onehot: got %0h, expected one-hot or zero", FrameStrobe);
            end
            if (FrameStrobe != 0 || m_prev_strobe != 0) begin
                n_checks++;
                if (FrameData !== m_prev_data) begin
                    n_err++;
                    $display("FAIL data_stable: got %0h, expected %0h", FrameData, m_prev_data);
                end
            end
        end
        m_prev_strobe = FrameStrobe;
        m_prev_data   = FrameData;
    end

    // Called at a negedge; returns at the negedge right after the transfer.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) chk("send_timeout", in_ready, 1'b1);
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic send3(input logic [31:0] w);
        int n;
        n = 0;
        in_data3  = w;
        in_valid3 = 1'b1;
        while (in_ready3 !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) chk("send3_timeout", in_ready3, 1'b1);
        @(negedge CLK);
        in_valid3 = 1'b0;
    endtask

    // Entered one cycle after the last data word (SETUP cycle).
    task automatic check_frame(input logic [19:0] s);
        chk("setup_strobe", FrameStrobe, 20'h0);
        chk("setup_ready", in_ready, 1'b0);
        chk("setup_busy", busy, 1'b1);
        chk("setup_data", FrameData, exp_data);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            chk("strobe", FrameStrobe, s);
            chk("strobe_ready", in_ready, 1'b0);
        end
        @(negedge CLK);
        chk("hold_strobe", FrameStrobe, 20'h0);
        chk("hold_ready", in_ready, 1'b0);
        chk("hold_data", FrameData, exp_data);
        chk("hold_cnt", frame_count, exp_cnt);
        exp_cnt = exp_cnt + 16'd1;
        @(negedge CLK);
        chk("done_ready", in_ready, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_cnt", frame_count, exp_cnt);
    endtask

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] dat;
        logic        has_dat;
        logic [19:0] exp_strobe;
        logic        exp_frame;
        logic        exp_err;
    } vec_t;

    vec_t        vt[7];
    logic [7:0]  ix;
    logic [31:0] d;

    initial begin
        vt[0] = '{32'hFA000005, 32'hDEADBEEF, 1'b1, 20'h00020, 1'b1, 1'b0};
        vt[1] = '{32'hFA000000, 32'h01234567, 1'b1, 20'h00001, 1'b1, 1'b0};
        vt[2] = '{32'hFA000013, 32'hCAFEF00D, 1'b1, 20'h80000, 1'b1, 1'b0};
        vt[3] = '{32'hFAFFFF0A, 32'h5A5A5A5A, 1'b1, 20'h00400, 1'b1, 1'b0};
        vt[4] = '{32'h12000003, 32'h0,        1'b0, 20'h00000, 1'b0, 1'b1};
        vt[5] = '{32'hFA000014, 32'h77777777, 1'b1, 20'h00000, 1'b0, 1'b1};
        vt[6] = '{32'hFA0000FF, 32'h88888888, 1'b1, 20'h00000, 1'b0, 1'b1};

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_data", FrameData, 32'h0);
        chk("rst_strobe", FrameStrobe, 20'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_cnt", frame_count, 16'h0);
        reset = 1'b0;
        @(negedge CLK);
        chk("idle_ready", in_ready, 1'b1);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            send(vt[i].hdr);
            if (!vt[i].has_dat) begin
                chk("badsync_busy", busy, 1'b0);
                chk("badsync_ready", in_ready, 1'b1);
            end else begin
                chk("hdr_busy", busy, 1'b1);
                send(vt[i].dat);
                if (vt[i].exp_frame) begin
                    exp_data = vt[i].dat;
                    check_frame(vt[i].exp_strobe);
                end else begin
                    chk("disc_ready", in_ready, 1'b1);
                    chk("disc_busy", busy, 1'b0);
                    chk("disc_data", FrameData, exp_data);
                    @(negedge CLK);
                    @(negedge CLK);
                    chk("disc_strobe", FrameStrobe, 20'h0);
                    chk("disc_cnt", frame_count, exp_cnt);
                end
            end
            chk("vec_err", err, vt[i].exp_err);
        end

        // Error set wins over clear in the same cycle, then clear alone
        clear_err = 1'b1;
        send(32'h12000003);
        clear_err = 1'b0;
        chk("err_set_wins", err, 1'b1);
        clear_err = 1'b1;
        @(negedge CLK);
        clear_err = 1'b0;
        chk("err_cleared", err, 1'b0);

        // NumRows=3: slices fill in order, gaps only stretch LOAD
        send3(32'hFA000013);
        chk("r3_busy", busy3, 1'b1);
        send3(32'h11111111);
        chk("r3_slice0", FrameData3, {64'h0, 32'h11111111});
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("r3_gap_ready", in_ready3, 1'b1);
            chk("r3_gap_strobe", FrameStrobe3, 20'h0);
        end
        send3(32'h22222222);
        send3(32'h33333333);
        chk("r3_data", FrameData3, 96'h333333332222222211111111);
        chk("r3_setup_strobe", FrameStrobe3, 20'h0);
        @(negedge CLK);
        chk("r3_strobe1", FrameStrobe3, 20'h80000);
        @(negedge CLK);
        chk("r3_strobe2", FrameStrobe3, 20'h80000);
        @(negedge CLK);
        chk("r3_hold", FrameStrobe3, 20'h0);
        @(negedge CLK);
        chk("r3_cnt", frame_count3, 16'd1);
        chk("r3_ready", in_ready3, 1'b1);

        // Reset during the second strobe cycle
        send(32'hFA000007);
        send(32'h0BADF00D);
        @(negedge CLK);
        chk("mid_strobe1", FrameStrobe, 20'h00080);
        @(negedge CLK);
        chk("mid_strobe2", FrameStrobe, 20'h00080);
        reset = 1'b1;
        @(negedge CLK);
        chk("mid_rst_strobe", FrameStrobe, 20'h0);
        chk("mid_rst_data", FrameData, 32'h0);
        chk("mid_rst_cnt", frame_count, 16'h0);
        chk("mid_rst_busy", busy, 1'b0);
        reset = 1'b0;
        exp_cnt = 16'h0;
        exp_data = 32'h0;
        @(negedge CLK);
        chk("mid_idle_ready", in_ready, 1'b1);
        send(32'hFA000002);
        send(32'h13572468);
        exp_data = 32'h13572468;
        check_frame(20'h00004);

        // Counter wrap: preload near the top, then back-to-back frames
        force u_dut.r_frame_cnt = 16'hFFFA;
        @(negedge CLK);
        release u_dut.r_frame_cnt;
        exp_cnt = 16'hFFFA;
        chk("wrap_preload", frame_count, 16'hFFFA);
        for (int i = 0; i < 300; i++) begin
            ix = 8'(i % 20);
            d  = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
            send({8'hFA, 16'h0, ix});
            send(d);
            exp_data = d;
            check_frame(20'd1 << ix);
        end
        chk("wrap_final", frame_count, 16'h0126);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/config_frame_loader.md
# config_frame_loader

Sequencer that converts a 32-bit word stream, coming from the configuration port (USB/UART bridge), into frame writes on a tile column's configuration latches. It drives the shared FrameData bus and a one-hot FrameStrobe vector with guaranteed setup and hold around each strobe pulse. It sits between the bitstream receiver and the column's frame-latch config memories, one instance per column.

## Interface
- MaxFramesPerCol, 20, width of FrameStrobe; number of addressable frames.
- FrameBitsPerRow, 32, bits per row slice of FrameData; fixed at 32, equal to the stream word width.
- NumRows, 1, row slices per frame; FrameData width is FrameBitsPerRow*NumRows; range 1–16.
- StrobeCycles, 2, FrameStrobe pulse length in cycles; must be ≥1.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  32  stream word (header or frame data).
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a word; a transfer occurs on in_valid && in_ready.
- clear_err  in  1  clears err.
- FrameData  out  FrameBitsPerRow*NumRows  frame data to the latches.
- FrameStrobe  out  MaxFramesPerCol  one-hot frame write strobe.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky protocol error.
- frame_count  out  16  frames successfully written; wraps 0xFFFF→0.

## Operation
- Header word format: [31:24] sync = 8'hFA; [23:8] ignored; [7:0] frame index.
- IDLE: in_ready=1. On an accepted word:
  - bad sync: the word is dropped, err is set, stay in IDLE.
  - good sync, index < MaxFramesPerCol: latch the index, clear the row counter, go to LOAD.
  - good sync, index ≥ MaxFramesPerCol: set err, go to DISCARD.
- LOAD: in_ready=1. The k-th accepted word (k=0..NumRows-1) is written to FrameData[32k+31:32k]. Other slices keep their value. After word NumRows-1, go to SETUP.
- DISCARD: in_ready=1. Accept NumRows words, leave FrameData untouched, return to IDLE. No strobe is issued and frame_count does not change.
- SETUP: 1 cycle; in_ready=0, FrameStrobe=0.
- STROBE: StrobeCycles cycles; FrameStrobe = 1<<index, all other bits 0.
- HOLD: 1 cycle; FrameStrobe=0; frame_count increments; go to IDLE.
- FrameData changes only on accepted LOAD words. It holds its value after a frame and through IDLE, and never changes while FrameStrobe≠0 or in SETUP/HOLD.
- FrameStrobe is never multi-hot and is zero outside STROBE.
- err: set by a bad sync or a bad index; cleared by clear_err; set wins if both happen in the same cycle.
- No in_valid in LOAD/DISCARD: wait indefinitely, no timeout.

## Timing
- Reset values: in_ready=0 during the reset cycle, then 1 (IDLE). FrameData=0, FrameStrobe=0, busy=0, err=0, frame_count=0.
- Reset asserted mid-operation: on that edge, state goes to IDLE, FrameStrobe=0, FrameData=0, the partial frame is lost and the count is not incremented.
- in_ready is registered from state only; it does not combinationally depend on in_valid.
- Last data word accepted at edge t:
  - SETUP in cycle t+1.
  - FrameStrobe high in cycles t+2 … t+1+StrobeCycles.
  - HOLD in cycle t+2+StrobeCycles.
  - frame_count updated and in_ready=1 from cycle t+3+StrobeCycles.
- Minimum frame period with a continuous stream: NumRows+1 accept cycles plus StrobeCycles+2.
- busy rises the cycle after the header is accepted and falls in the same cycle in_ready returns to 1 after HOLD.

## Test plan
- Defaults: header 0xFA000005, data 0xDEADBEEF → FrameData=0xDEADBEEF one cycle before FrameStrobe=0x00020 for exactly 2 cycles; frame_count=1; FrameData unchanged through HOLD.
- NumRows=3: header 0xFA000013, words 0x11111111, 0x22222222, 0x33333333 → FrameData=0x333333332222222211111111; FrameStrobe bit 19 only; in_valid gaps inside LOAD only stretch LOAD.
- Bad sync 0x12000003 → err=1, no strobe, still IDLE. Then header 0xFA000014 plus one word → err stays 1, word consumed, no strobe, frame_count unchanged. Assert clear_err → err=0.
- Reset asserted during the second STROBE cycle → FrameStrobe=0 and FrameData=0 on the next cycle, frame_count=0, next header accepted normally.
- 65536 back-to-back frames (index cycling 0..19) → frame_count wraps to 0. Checker confirms FrameStrobe is always one-hot-or-zero and FrameData is stable from one cycle before through one cycle after every strobe.
